// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared encodings and default widths for the fetch/loader instruction memory arbiter.
package fetch_mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_BURST = 16;

  // Last-owner state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_M0   = 2'd1,
    TAG_M1   = 2'd2
  } resp_tag_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive loader grants while fetch waits; flags when fetch must be forced through.
module arb_starve_cnt #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority so a forced fetch grant restarts the window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sat = (r_cnt == CNT_W'(MAX_BURST));

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Shares one 1-cycle-latency instruction memory between core fetch (m0) and loader/debug (m1).
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              hold_flag
);

  logic       w_sat;
  logic       w_m0_gnt;
  logic       w_m1_gnt;
  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  resp_tag_e  r_tag;
  resp_tag_e  w_tag_nxt;

  // Loader wins contention until the starvation window fills; nothing is granted in reset
  assign w_m0_gnt = ~rst & m0_req & (~m1_req | w_sat);
  assign w_m1_gnt = ~rst & m1_req & ~w_m0_gnt;

  arb_starve_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_m1_gnt & m0_req),
    .i_clr (w_m0_gnt | ~m0_req),
    .o_sat (w_sat)
  );

  assign m0_gnt    = w_m0_gnt;
  assign m1_gnt    = w_m1_gnt;
  assign mem_en    = w_m0_gnt | w_m1_gnt;
  assign hold_flag = m0_req & ~w_m0_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_m0_gnt) begin
      mem_addr = m0_addr;
    end else if (w_m1_gnt) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tag   <= TAG_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

  // Owner tracking plus the tag of the read whose data arrives next cycle
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_tag_nxt   = TAG_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_m0_gnt)      w_state_nxt = ST_OWN0;
        else if (w_m1_gnt) w_state_nxt = ST_OWN1;
      end
      ST_OWN0: begin
        if (w_m1_gnt)      w_state_nxt = ST_OWN1;
        else if (w_m0_gnt) w_state_nxt = ST_OWN0;
      end
      ST_OWN1: begin
        if (w_m0_gnt)      w_state_nxt = ST_OWN0;
        else if (w_m1_gnt) w_state_nxt = ST_OWN1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_m0_gnt) begin
      w_tag_nxt = TAG_M0;
    end else if (w_m1_gnt && !m1_we) begin
      w_tag_nxt = TAG_M1;
    end
  end

  assign m0_rvalid = (r_tag == TAG_M0);
  assign m1_rvalid = (r_tag == TAG_M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Arbitrates one single-port synchronous instruction memory (1-cycle read latency) between two requesters.
- Master 0 is the core instruction fetch (read-only). Master 1 is the program loader/debug port (read/write), which fills memory at runtime.
- Routes read data back to the owning master and drives a fetch stall flag to the core while fetch is blocked.
- Sits between the core fetch stage and the instruction memory inside the SoC top.

Parameters:
ADDR_W, 32, address width of both masters and the memory port
DATA_W, 32, data width
MAX_BURST, 16, consecutive master-1 grants allowed while master 0 waits before master 0 is forced through (range 1..255)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
m0_req  in  1  fetch read request
m0_addr  in  ADDR_W  fetch address
m0_gnt  out  1  fetch request accepted this cycle
m0_rvalid  out  1  fetch read data valid
m0_rdata  out  DATA_W  fetch read data
m1_req  in  1  loader request
m1_we  in  1  loader write enable (1 = write, 0 = read)
m1_addr  in  ADDR_W  loader address
m1_wdata  in  DATA_W  loader write data
m1_gnt  out  1  loader request accepted this cycle
m1_rvalid  out  1  loader read data valid
m1_rdata  out  DATA_W  loader read data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read is accepted
hold_flag  out  1  fetch stall to core: m0_req and not m0_gnt

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; burst counter 0; response tag NONE.
  - m0_rvalid and m1_rvalid are 0.
  - With no requests, every output is 0.
- Handshake:
  - A request is accepted in the cycle req=1 and gnt=1.
  - The master holds req, addr, we and wdata stable until gnt.
  - At most one grant per cycle.
- Grants and memory port:
  - Grants are combinational from the current requests and registered state.
  - mem_en = m0_gnt | m1_gnt. mem_we, mem_addr and mem_wdata are muxed from the granted master.
  - When nothing is granted, mem_we=0 and addr/wdata=0.
- Priority:
  - Only one master requesting: that master is granted.
  - Both requesting: master 1 wins, unless burst_cnt == MAX_BURST. Then master 0 wins for exactly that cycle.
- Burst counter:
  - Increments when m1 is granted and m0_req=1. Saturates at MAX_BURST.
  - Clears when m0 is granted, or when m0_req=0.
- State machine (records the last owner; used for response routing and debug):
  - IDLE -> OWN0 on m0 grant; IDLE -> OWN1 on m1 grant.
  - OWN0 / OWN1 move to the other OWN state on a grant to the other master.
  - Any state -> IDLE on a cycle with no grant.
- Read response:
  - The response tag is registered at an accepted read: 0, 1, or NONE for a write or no grant.
  - Next cycle, the matching rvalid = 1 and its rdata = mem_rdata. The non-matching rdata is 0.
  - Writes produce no response.
  - Back-to-back reads from alternating masters return correctly in consecutive cycles.
- hold_flag is combinational; it is 0 whenever m0_req=0.
- Reset mid-access: a pending response is discarded and no rvalid is issued after reset release.
- MAX_BURST=1 alternates strictly under continuous contention.

Decomposition:
- Shared package:
  - owner/state encoding: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - response tag encoding: NONE, M0, M1;
  - default widths.
- The burst counter with saturate/clear is a natural sub-module: arb_starve_cnt.
- Grant logic and the response mux stay in the top.

Test Plan:
- Reset:
  - Stimulus: rst=1 with m0_req=m1_req=1.
  - Required: all gnt/rvalid/mem_en=0. After release, first cycle m1_gnt=1, m0_gnt=0, hold_flag=1.
- Fetch only:
  - Stimulus: m0 reads addr 0x0,0x4,0x8; memory returns 0x00100093, 0x00200113, 0x002081B3.
  - Required: m0_gnt each cycle; m0_rvalid one cycle later with matching data; hold_flag=0.
- Loader write then fetch:
  - Stimulus: m1 writes 0x0040_0E13 to addr 0x10, then m0 reads 0x10.
  - Required: mem_we=1 and addr 0x10 in the write cycle; m1_rvalid never asserts; m0_rdata=0x00400E13.
- Starvation limit:
  - Stimulus: both request continuously, MAX_BURST=16.
  - Required: 16 m1 grants, then 1 m0 grant, then repeating. hold_flag=1 during the 16-cycle runs.
- Alternating reads:
  - Stimulus: m1 read 0x20, then m0 read 0x24 in consecutive cycles.
  - Required: m1_rvalid with data@0x20 in the next cycle, followed by m0_rvalid with data@0x24. No cross-routing.
- Mid-operation reset:
  - Stimulus: assert rst the cycle after an accepted m0 read.
  - Required: m0_rvalid=0 immediately; state IDLE; burst_cnt=0.
